// File: rtl/uart_pkg.sv
// Shared UART definitions: received byte type, width constant and a saturating counter helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Byte storage for the RX FIFO: simple dual-port, synchronous write, asynchronous (show-ahead) read.
module fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  uart_byte_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output uart_byte_t    rdata_o
);

  // Contents are never reset; occupancy tracking in the parent decides what is valid.
  uart_byte_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: 1-cycle push-to-output latency, no bypass; incoming bytes cannot be stalled and are dropped when full.
// Sticky overflow flag; UART_RX_FIFO_STATS_EN adds a saturating drop_count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  uart_byte_t               in_data,
  input  logic                     in_valid,
  output uart_byte_t               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     overflow_clear
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, drop;
  uart_byte_t    head;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign push      = in_valid && ((count_q != FULL_CNT) || pop);
  assign drop      = in_valid && !push;

  always_comb begin
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A drop coinciding with a clear restarts the count at one rather than losing the event.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_clear) begin
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push && rst_n),
    .waddr_i (wptr_q),
    .wdata_i (in_data),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  assign out_data = head;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  uart_byte_t in_data;
  logic       in_valid;
  uart_byte_t out_data;
  logic       out_valid;
  logic       out_ready;
  logic [$clog2(DEPTH):0] count;
  logic       overflow;
  logic       overflow_clear;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
`ifdef UART_RX_FIFO_STATS_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus flag and drop tally, updated from the sampled inputs.
  uart_byte_t m_q[$];
  uart_byte_t m_out[$];
  bit         m_ovf;
  int         m_drops;

  always @(posedge clk) begin
    bit p, acc, d;
    if (!rst_n) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      p   = (m_q.size() != 0) && out_ready;
      acc = in_valid && ((m_q.size() < DEPTH) || p);
      d   = in_valid && !acc;
      if (p) m_out.push_back(m_q.pop_front());
      if (acc) m_q.push_back(in_data);
      if (d) m_ovf = 1'b1;
      else if (overflow_clear) m_ovf = 1'b0;
      if (overflow_clear) m_drops = d ? 1 : 0;
      else if (d && m_drops < 65535) m_drops++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_count", int'(count), m_q.size());
      chk("cmp_out_valid", int'(out_valid), int'(m_q.size() != 0));
      if (m_q.size() != 0) chk("cmp_out_data", int'(out_data), int'(m_q[0]));
      chk("cmp_overflow", int'(overflow), int'(m_ovf));
`ifdef UART_RX_FIFO_STATS_EN
      chk("cmp_drop_count", int'(drop_count), m_drops);
`endif
    end
  end

  task automatic step(input bit iv, input int d, input bit rdy, input bit clr);
    in_valid       = iv;
    in_data        = uart_byte_t'(d);
    out_ready      = rdy;
    overflow_clear = clr;
    @(posedge clk);
    #1;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    overflow_clear = 1'b0;
  endtask

  task automatic chk_dc(input string name, input int exp);
`ifdef UART_RX_FIFO_STATS_EN
    chk(name, int'(drop_count), exp);
`else
    if (exp < 0) chk(name, exp, 0);
`endif
  endtask

  initial begin
    uart_byte_t exp_seq[$];
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; overflow_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("reset_count", int'(count), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk_dc("reset_drop_count", 0);

    // Single byte in, then out.
    step(1, 8'hA5, 0, 0);
    chk("single_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 8'hA5);
    chk("single_count", int'(count), 1);
    step(0, 0, 1, 0);
    chk("single_drained_count", int'(count), 0);
    chk("single_drained_valid", int'(out_valid), 0);

    // Overfill by one, then full push-while-pop, then drain.
    for (int i = 0; i <= DEPTH; i++) step(1, i, 0, 0);
    chk("overfill_count", int'(count), DEPTH);
    chk("overfill_overflow", int'(overflow), 1);
    chk_dc("overfill_drop_count", 1);
    m_out.delete();
    step(1, 8'h3C, 1, 0);
    chk("full_pushpop_count", int'(count), DEPTH);
    chk_dc("full_pushpop_drop_count", 1);
    n = 0;
    while (out_valid && n < 40) begin
      step(0, 0, 1, 0);
      n++;
    end
    chk("drain_len", m_out.size(), DEPTH + 1);
    for (int i = 0; i < m_out.size() && i <= DEPTH; i++)
      chk("drain_order", int'(m_out[i]), (i < DEPTH) ? i : 8'h3C);

    // Overflow set/clear priority.
    step(0, 0, 0, 1);
    chk("clear_overflow", int'(overflow), 0);
    chk_dc("clear_drop_count", 0);
    for (int i = 0; i < DEPTH + 2; i++) step(1, 8'h40 + i, 0, 0);
    chk_dc("two_drops", 2);
    step(1, 8'hEE, 0, 1);
    chk("drop_and_clear_overflow", int'(overflow), 1);
    chk_dc("drop_and_clear_count", 1);
    step(0, 0, 0, 1);
    chk("clear_alone_overflow", int'(overflow), 0);
    chk_dc("clear_alone_count", 0);
    step(1, 8'hEF, 0, 0);
    chk("redrop_overflow", int'(overflow), 1);

    // Reset mid-operation with 5 entries, inputs active during reset.
    repeat (DEPTH - 5) step(0, 0, 1, 0);
    chk("pre_reset_count", int'(count), 5);
    rst_n = 1'b0;
    step(1, 8'h99, 1, 0);
    rst_n = 1'b1;
    chk("mid_reset_count", int'(count), 0);
    chk("mid_reset_valid", int'(out_valid), 0);
    chk("mid_reset_overflow", int'(overflow), 0);
    chk_dc("mid_reset_drop_count", 0);
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    chk("post_reset_count", int'(count), 2);
    chk("post_reset_head", int'(out_data), 8'h11);
    repeat (2) step(0, 0, 1, 0);

    // Push and pop together for 40 cycles across pointer wrap.
    step(1, 8'h80, 0, 0);
    exp_seq.delete();
    exp_seq.push_back(8'h80);
    m_out.delete();
    for (int i = 0; i < 40; i++) begin
      int d;
      d = $urandom_range(0, 255);
      exp_seq.push_back(uart_byte_t'(d));
      step(1, d, 1, 0);
      chk("stream_count", int'(count), 1);
    end
    chk("stream_len", m_out.size(), 40);
    for (int i = 0; i < 40 && i < m_out.size(); i++)
      chk("stream_data", int'(m_out[i]), int'(exp_seq[i]));
    step(0, 0, 1, 0);

    // Randomised traffic with varying consumer rate.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 500) % 3;
      rst_n = ($urandom_range(0, 999) != 0);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 255),
           $urandom_range(0, 3) < bias + 1, $urandom_range(0, 31) == 0);
      rst_n = 1'b1;
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
